// File: rtl/int_mul_wb_queue_if.sv
// Bundles the issue, multiplier-result, writeback and hazard-check signals
// of the multiplier writeback queue.
interface int_mul_wb_queue_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned TAG_W = 5
);
  logic             iss_fire;
  logic [TAG_W-1:0] iss_rd;
  logic             tag_full;
  logic             mul_valid;
  logic             mul_ready;
  logic [N-1:0]     mul_y;
  logic             wb_valid;
  logic             wb_ready;
  logic [TAG_W-1:0] wb_rd;
  logic [N-1:0]     wb_data;
  logic [TAG_W-1:0] chk_rs1;
  logic [TAG_W-1:0] chk_rs2;
  logic             rs1_hit;
  logic             rs2_hit;

  // Pipeline side: issue, multiplier, writeback port and decode
  modport master (
    output iss_fire, iss_rd, mul_valid, mul_y, wb_ready, chk_rs1, chk_rs2,
    input  tag_full, mul_ready, wb_valid, wb_rd, wb_data, rs1_hit, rs2_hit
  );

  // Queue side
  modport slave (
    input  iss_fire, iss_rd, mul_valid, mul_y, wb_ready, chk_rs1, chk_rs2,
    output tag_full, mul_ready, wb_valid, wb_rd, wb_data, rs1_hit, rs2_hit
  );
endinterface

// File: rtl/int_mul_wb_queue.sv
// Multiplier writeback queue: tags each issued multiply with its destination
// register, pairs the tag with the multiplier result, buffers tagged results
// for the register-file writeback port and flags pending destinations so
// decode can stall dependent instructions.
module int_mul_wb_queue #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  int_mul_wb_queue_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [PW-1:0]    tag_wp, tag_rp;
  logic [CW-1:0]    tag_cnt;

  logic [TAG_W-1:0] res_rd_mem   [DEPTH];
  logic [N-1:0]     res_data_mem [DEPTH];
  logic [PW-1:0]    res_wp, res_rp;
  logic [CW-1:0]    res_cnt;

  logic             tag_push, tag_pop, mul_fire;
  logic             res_push, res_pop, wb_valid_i;
  logic [TAG_W-1:0] tag_head;

  // Handshake decode; status flags come only from registered counts
  always_comb begin
    bus.tag_full  = (tag_cnt == FULL_CNT);
    bus.mul_ready = (res_cnt != FULL_CNT);
    wb_valid_i    = (res_cnt != '0);
    tag_push      = bus.iss_fire && !bus.tag_full;
    mul_fire      = bus.mul_valid && bus.mul_ready;
    tag_pop       = mul_fire && (tag_cnt != '0);
    tag_head      = tag_mem[tag_rp];
    res_push      = tag_pop && (tag_head != '0);
    res_pop       = wb_valid_i && bus.wb_ready;
  end

  // Tag FIFO storage
  always_ff @(posedge clk) begin
    if (tag_push) tag_mem[tag_wp] <= bus.iss_rd;
  end

  // Tag FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_wp  <= '0;
      tag_rp  <= '0;
      tag_cnt <= '0;
    end else begin
      if (tag_push) tag_wp <= tag_wp + 1'b1;
      if (tag_pop)  tag_rp <= tag_rp + 1'b1;
      case ({tag_push, tag_pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  // Result FIFO storage
  always_ff @(posedge clk) begin
    if (res_push) begin
      res_rd_mem[res_wp]   <= tag_head;
      res_data_mem[res_wp] <= bus.mul_y;
    end
  end

  // Result FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_wp  <= '0;
      res_rp  <= '0;
      res_cnt <= '0;
    end else begin
      if (res_push) res_wp <= res_wp + 1'b1;
      if (res_pop)  res_rp <= res_rp + 1'b1;
      case ({res_push, res_pop})
        2'b10:   res_cnt <= res_cnt + 1'b1;
        2'b01:   res_cnt <= res_cnt - 1'b1;
        default: res_cnt <= res_cnt;
      endcase
    end
  end

  // Writeback head; forced to zero while empty so reset and drain look clean
  always_comb begin
    bus.wb_valid = wb_valid_i;
    bus.wb_rd    = wb_valid_i ? res_rd_mem[res_rp]   : '0;
    bus.wb_data  = wb_valid_i ? res_data_mem[res_rp] : '0;
  end

  // Pending-destination match over every occupied slot of both FIFOs
  always_comb begin : hazard
    logic          hit1, hit2;
    logic [PW-1:0] t_off, r_off;
    hit1  = 1'b0;
    hit2  = 1'b0;
    t_off = '0;
    r_off = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      // Slot i is occupied when its distance from the read pointer is below the count
      t_off = PW'(i) - tag_rp;
      if ({1'b0, t_off} < tag_cnt) begin
        if (tag_mem[i] == bus.chk_rs1) hit1 = 1'b1;
        if (tag_mem[i] == bus.chk_rs2) hit2 = 1'b1;
      end
      r_off = PW'(i) - res_rp;
      if ({1'b0, r_off} < res_cnt) begin
        if (res_rd_mem[i] == bus.chk_rs1) hit1 = 1'b1;
        if (res_rd_mem[i] == bus.chk_rs2) hit2 = 1'b1;
      end
    end
    bus.rs1_hit = (bus.chk_rs1 != '0) && hit1;
    bus.rs2_hit = (bus.chk_rs2 != '0) && hit2;
  end

endmodule
